reg_scan_bank: RTL

REG_SCAN_BANK -- requirements
Module: reg_scan_bank

---
 rtl/reg_scan_bank_if.sv | 31 +++
 rtl/reg_scan_bank.sv | 100 ++++++++++
 2 files changed

// File: rtl/reg_scan_bank_if.sv
// Bus bundle for reg_scan_bank: register-bank write port, scan control,
// the eight registered entries, and scan status.
interface reg_scan_bank_if;
  logic        we;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic        clr;
  logic        start;
  logic        hold;
  logic [31:0] x0;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [31:0] x3;
  logic [31:0] x4;
  logic [31:0] x5;
  logic [31:0] x6;
  logic [31:0] x7;
  logic [2:0]  sel;
  logic        busy;
  logic        done;

  modport master (
    output we, waddr, wdata, clr, start, hold,
    input  x0, x1, x2, x3, x4, x5, x6, x7, sel, busy, done
  );

  modport slave (
    input  we, waddr, wdata, clr, start, hold,
    output x0, x1, x2, x3, x4, x5, x6, x7, sel, busy, done
  );
endinterface

// File: rtl/reg_scan_bank.sv
// Eight-entry 32-bit register bank with a scan sequencer that presents
// each entry index on sel for DWELL non-held cycles, then pulses done.
//
// state  | meaning
// IDLE   | waiting for start; sel keeps its last value
// SCAN   | presenting entries 0..7, busy high, dwell counter running
// DONE   | one-cycle done pulse, always returns to IDLE
module reg_scan_bank #(
  parameter int unsigned DWELL = 4
) (
  input logic           clk,
  input logic           rst_n,
  reg_scan_bank_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Counter counts down from DWELL-1, so an index stays up DWELL cycles.
  localparam logic [7:0] RELOAD = 8'(DWELL - 1);

  logic [31:0] entry [8];
  logic [1:0]  state, state_nxt;
  logic [2:0]  sel_q, sel_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        busy_q, done_q;

  // Register bank: clear wins over write; independent of scan state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) entry[i] <= '0;
    end else if (bus.clr) begin
      for (int i = 0; i < 8; i++) entry[i] <= '0;
    end else if (bus.we) begin
      entry[bus.waddr] <= bus.wdata;
    end
  end

  // Scan next-state: hold freezes SCAN only; DONE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_SCAN;
          sel_nxt   = '0;
          cnt_nxt   = RELOAD;
        end
      end
      S_SCAN: begin
        if (!bus.hold) begin
          if (cnt != 8'd0) begin
            cnt_nxt = cnt - 8'd1;
          end else if (sel_q != 3'd7) begin
            sel_nxt = sel_q + 3'd1;
            cnt_nxt = RELOAD;
          end else begin
            state_nxt = S_DONE;
          end
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sequencer registers; busy/done are flopped from the next state so
  // they are glitch-free and line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      sel_q  <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel_q  <= sel_nxt;
      cnt    <= cnt_nxt;
      busy_q <= (state_nxt == S_SCAN);
      done_q <= (state_nxt == S_DONE);
    end
  end

  assign bus.x0   = entry[0];
  assign bus.x1   = entry[1];
  assign bus.x2   = entry[2];
  assign bus.x3   = entry[3];
  assign bus.x4   = entry[4];
  assign bus.x5   = entry[5];
  assign bus.x6   = entry[6];
  assign bus.x7   = entry[7];
  assign bus.sel  = sel_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
